// File: rtl/lcm_chk_pkg.sv
// ---------------------------------------------------------------------------
// lcm_chk_pkg
// Shared definitions for the GCD/LCM result checker: the checker FSM state
// encoding and the bit positions inside the 4-bit error code.
// ---------------------------------------------------------------------------
package lcm_chk_pkg;

  // IDLE waits for a transaction, MUL forms a*b and g*l, DIV forms a mod g
  // and b mod g, RESP presents the verdict until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Error code bit positions
  localparam int ERR_ZERO  = 0;
  localparam int ERR_DIV_A = 1;
  localparam int ERR_DIV_B = 2;
  localparam int ERR_PROD  = 3;

endpackage

// File: rtl/seq_mod_unit.sv
// ---------------------------------------------------------------------------
// seq_mod_unit
// Bit-serial restoring remainder: dividend mod divisor, one dividend bit per
// step, most significant bit first. DW steps after start the remainder is
// complete.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load dividend and clear the partial remainder
//   step        perform one restoring step
//   dividend    DW-bit dividend, sampled on start
//   divisor     DW-bit divisor, must be held stable while stepping
//   rem_o       DW+1-bit partial remainder
// ---------------------------------------------------------------------------
module seq_mod_unit
  import lcm_chk_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_o
);

  logic [DW:0]   r_rem;
  logic [DW-1:0] r_dvd;
  logic [DW:0]   w_trial;
  logic [DW:0]   w_next;

  // Shift the next dividend bit into the partial remainder and subtract the
  // divisor whenever it fits (restoring: otherwise keep the shifted value).
  always_comb begin
    w_trial = {r_rem[DW-1:0], r_dvd[DW-1]};
    if (w_trial >= {1'b0, divisor}) begin
      w_next = w_trial - {1'b0, divisor};
    end else begin
      w_next = w_trial;
    end
  end

  // While stepping, rem_o already includes the current step, so the caller
  // can register a verdict on the very edge of the final step.
  assign rem_o = step ? w_next : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_dvd <= '0;
    end else if (start) begin
      r_rem <= '0;
      r_dvd <= dividend;
    end else if (step) begin
      r_rem <= w_next;
      r_dvd <= {r_dvd[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/lcm_result_checker.sv
// ---------------------------------------------------------------------------
// lcm_result_checker
// Sink-side companion to the GCD/LCM engine. Accepts one transaction (a, b,
// claimed gcd, claimed lcm), checks that gcd divides a and b and that
// gcd*lcm == a*b using bit-serial arithmetic, then reports pass/fail with an
// error code and keeps saturating pass/fail counters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   transaction handshake (ready only in IDLE)
//   data_a, data_b      operands
//   gcd_i, lcm_i        engine's claimed gcd and (possibly truncated) lcm
//   chk_valid/chk_ready result handshake
//   chk_pass            1 when err_code is zero
//   err_code            [0] ZERO, [1] DIV_A, [2] DIV_B, [3] PROD
//   pass_cnt, fail_cnt  saturating result counters
// ---------------------------------------------------------------------------
module lcm_result_checker
  import lcm_chk_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  input  logic [DW-1:0] gcd_i,
  input  logic [DW-1:0] lcm_i,
  output logic          chk_valid,
  input  logic          chk_ready,
  output logic          chk_pass,
  output logic [3:0]    err_code,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt
);

  localparam int SW = (DW > 1) ? $clog2(DW) : 1;

  state_t          r_state;
  logic [SW-1:0]   r_step;
  logic [2*DW-1:0] r_a_sh;
  logic [2*DW-1:0] r_g_sh;
  logic [DW-1:0]   r_b_mul;
  logic [DW-1:0]   r_l_mul;
  logic [2*DW-1:0] r_pa;
  logic [2*DW-1:0] r_pg;
  logic [DW-1:0]   r_g;
  logic [3:0]      r_err;
  logic            r_pass;
  logic [CW-1:0]   r_pass_cnt;
  logic [CW-1:0]   r_fail_cnt;

  logic            w_accept;
  logic            w_zero;
  logic            w_last;
  logic            w_hs;
  logic            w_div_step;
  logic [DW:0]     w_ra;
  logic [DW:0]     w_rb;
  logic [3:0]      w_err;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_zero     = (data_a == '0) || (data_b == '0) || (gcd_i == '0);
  assign w_last     = (r_step == SW'(DW - 1));
  assign w_hs       = (r_state == ST_RESP) && chk_ready;
  assign w_div_step = (r_state == ST_DIV);

  assign in_ready  = (r_state == ST_IDLE);
  assign chk_valid = (r_state == ST_RESP);
  assign chk_pass  = r_pass;
  assign err_code  = r_err;
  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;

  // Remainder units are loaded at accept and step through the DIV phase.
  seq_mod_unit #(.DW(DW)) u_mod_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_accept && !w_zero),
    .step     (w_div_step),
    .dividend (data_a),
    .divisor  (r_g),
    .rem_o    (w_ra)
  );

  seq_mod_unit #(.DW(DW)) u_mod_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_accept && !w_zero),
    .step     (w_div_step),
    .dividend (data_b),
    .divisor  (r_g),
    .rem_o    (w_rb)
  );

  // Verdict assembled from the final remainders and the two full products.
  always_comb begin
    w_err            = '0;
    w_err[ERR_DIV_A] = (w_ra != '0);
    w_err[ERR_DIV_B] = (w_rb != '0);
    w_err[ERR_PROD]  = (r_pa != r_pg);
  end

  // Two shift-add multipliers running side by side: the multiplicand shifts
  // left, the multiplier shifts right, one partial product per MUL step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_g_sh  <= '0;
      r_b_mul <= '0;
      r_l_mul <= '0;
      r_pa    <= '0;
      r_pg    <= '0;
      r_g     <= '0;
    end else if (w_accept) begin
      r_a_sh  <= {{DW{1'b0}}, data_a};
      r_g_sh  <= {{DW{1'b0}}, gcd_i};
      r_b_mul <= data_b;
      r_l_mul <= lcm_i;
      r_pa    <= '0;
      r_pg    <= '0;
      r_g     <= gcd_i;
    end else if (r_state == ST_MUL) begin
      if (r_b_mul[0]) begin
        r_pa <= r_pa + r_a_sh;
      end
      if (r_l_mul[0]) begin
        r_pg <= r_pg + r_g_sh;
      end
      r_a_sh  <= r_a_sh << 1;
      r_g_sh  <= r_g_sh << 1;
      r_b_mul <= r_b_mul >> 1;
      r_l_mul <= r_l_mul >> 1;
    end
  end

  // Control FSM. A zero operand or gcd short-cuts straight to RESP since the
  // arithmetic checks would be meaningless (and mod 0 undefined).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_step <= '0;
            if (w_zero) begin
              r_err   <= 4'b0001 << ERR_ZERO;
              r_pass  <= 1'b0;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (w_last) begin
            r_step  <= '0;
            r_state <= ST_DIV;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        ST_DIV: begin
          if (w_last) begin
            r_step  <= '0;
            r_err   <= w_err;
            r_pass  <= (w_err == 4'b0000);
            r_state <= ST_RESP;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        default: begin
          if (chk_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Counters move only on the result handshake and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (w_hs) begin
      if (r_pass) begin
        if (r_pass_cnt != {CW{1'b1}}) begin
          r_pass_cnt <= r_pass_cnt + CW'(1);
        end
      end else begin
        if (r_fail_cnt != {CW{1'b1}}) begin
          r_fail_cnt <= r_fail_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcm_result_checker.sv
// ---------------------------------------------------------------------------
// tb_lcm_result_checker
// Directed table of transactions with hand-computed verdicts, plus sequences
// for backpressure, reset during DIV and counter saturation. A second,
// narrow-counter instance shares every input so saturation is reachable in a
// handful of transactions.
// ---------------------------------------------------------------------------
module tb_lcm_result_checker;

  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int SCW = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] l;
    logic [3:0] err;
    int         lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid;
  logic [DW-1:0] dataA, dataB, gcdIn, lcmIn;
  logic          chkReady;
  logic          inReady, chkValid, chkPass;
  logic [3:0]    errCode;
  logic [CW-1:0] passCnt, failCnt;
  logic          satInReady, satChkValid, satChkPass;
  logic [3:0]    satErrCode;
  logic [SCW-1:0] satPassCnt, satFailCnt;

  int compCount = 0;
  int failCount = 0;
  int expPass   = 0;
  int expFail   = 0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  lcm_result_checker #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .data_a(dataA), .data_b(dataB), .gcd_i(gcdIn), .lcm_i(lcmIn),
    .chk_valid(chkValid), .chk_ready(chkReady), .chk_pass(chkPass),
    .err_code(errCode), .pass_cnt(passCnt), .fail_cnt(failCnt)
  );

  lcm_result_checker #(.DW(DW), .CW(SCW)) satDut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(satInReady),
    .data_a(dataA), .data_b(dataB), .gcd_i(gcdIn), .lcm_i(lcmIn),
    .chk_valid(satChkValid), .chk_ready(chkReady), .chk_pass(satChkPass),
    .err_code(satErrCode), .pass_cnt(satPassCnt), .fail_cnt(satFailCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one transaction at a falling edge, let it be accepted on the next
  // rising edge, then scramble the data lines.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] g, input logic [7:0] l);
    int guard = 0;
    @(negedge clk);
    while (!inReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready before accept", 32'(inReady), 1);
    inValid = 1'b1;
    dataA = a; dataB = b; gcdIn = g; lcmIn = l;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    dataA = 8'($urandom); dataB = 8'($urandom);
    gcdIn = 8'($urandom); lcmIn = 8'($urandom);
  endtask

  // Counts rising edges after the accept edge until chk_valid is seen.
  task automatic waitResult(output int lat, output logic readyLow);
    lat = 0;
    readyLow = 1'b1;
    @(negedge clk);
    while (!chkValid && lat < 40) begin
      if (inReady) readyLow = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (inReady) readyLow = 1'b0;
  endtask

  task automatic handshake(input logic passed);
    chkReady = 1'b1;
    @(posedge clk);
    #1;
    chkReady = 1'b0;
    if (passed) expPass++;
    else expFail++;
    @(negedge clk);
  endtask

  task automatic runTx(input string name, input vec_t v);
    int   lat;
    logic rl;
    applyStimulus(v.a, v.b, v.g, v.l);
    waitResult(lat, rl);
    checkOutput({name, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({name, " in_ready low"}, 32'(rl), 1);
    checkOutput({name, " err_code"}, 32'(errCode), 32'(v.err));
    checkOutput({name, " chk_pass"}, 32'(chkPass), 32'(v.err == 4'd0));
    handshake(v.err == 4'd0);
    checkOutput({name, " pass_cnt"}, 32'(passCnt), 32'(expPass));
    checkOutput({name, " fail_cnt"}, 32'(failCnt), 32'(expFail));
    checkOutput({name, " chk_valid after"}, 32'(chkValid), 0);
    checkOutput({name, " sat fail_cnt"}, 32'(satFailCnt),
                32'((expFail > 3) ? 3 : expFail));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    logic rl;
    logic stable;
    logic noValid;

    vecs[0] = '{8'd36,  8'd24,  8'd12,  8'd72,  4'b0000, 16};
    vecs[1] = '{8'd36,  8'd24,  8'd8,   8'd108, 4'b0010, 16};
    vecs[2] = '{8'd200, 8'd150, 8'd50,  8'd88,  4'b1000, 16};
    vecs[3] = '{8'd0,   8'd24,  8'd24,  8'd0,   4'b0001, 0};
    vecs[4] = '{8'd36,  8'd24,  8'd5,   8'd72,  4'b1110, 16};
    vecs[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 16};
    vecs[6] = '{8'd7,   8'd5,   8'd1,   8'd35,  4'b0000, 16};
    vecs[7] = '{8'd10,  8'd4,   8'd0,   8'd20,  4'b0001, 0};
    vecs[8] = '{8'd12,  8'd0,   8'd4,   8'd0,   4'b0001, 0};
    vecs[9] = '{8'd13,  8'd26,  8'd13,  8'd26,  4'b0000, 16};

    rst_n = 1'b0; inValid = 1'b0; chkReady = 1'b0;
    dataA = '0; dataB = '0; gcdIn = '0; lcmIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(inReady), 1);
    checkOutput("reset chk_valid", 32'(chkValid), 0);
    checkOutput("reset chk_pass", 32'(chkPass), 0);
    checkOutput("reset err_code", 32'(errCode), 0);
    checkOutput("reset pass_cnt", 32'(passCnt), 0);
    checkOutput("reset fail_cnt", 32'(failCnt), 0);
    rst_n = 1'b1;

    // chk_ready without chk_valid must not move anything
    chkReady = 1'b1;
    repeat (3) @(negedge clk);
    chkReady = 1'b0;
    checkOutput("idle ready pass_cnt", 32'(passCnt), 0);
    checkOutput("idle ready fail_cnt", 32'(failCnt), 0);
    checkOutput("idle ready chk_valid", 32'(chkValid), 0);

    for (int i = 0; i < 10; i++) begin
      runTx($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: verdict held while the consumer stalls and inputs churn
    applyStimulus(8'd36, 8'd24, 8'd12, 8'd72);
    waitResult(lat, rl);
    checkOutput("bp latency", 32'(lat), 16);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      dataA = 8'($urandom); dataB = 8'($urandom);
      gcdIn = 8'($urandom); lcmIn = 8'($urandom);
      @(negedge clk);
      if (!chkValid || !chkPass || errCode != 4'd0 || inReady ||
          passCnt != 16'(expPass)) stable = 1'b0;
    end
    inValid = 1'b0;
    checkOutput("bp stable while stalled", 32'(stable), 1);
    handshake(1'b1);
    checkOutput("bp pass_cnt", 32'(passCnt), 32'(expPass));
    checkOutput("bp in_ready after", 32'(inReady), 1);

    // Reset in the middle of DIV
    applyStimulus(8'd36, 8'd24, 8'd12, 8'd72);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    expPass = 0;
    expFail = 0;
    #1;
    checkOutput("mid rst in_ready", 32'(inReady), 1);
    checkOutput("mid rst chk_valid", 32'(chkValid), 0);
    checkOutput("mid rst err_code", 32'(errCode), 0);
    checkOutput("mid rst pass_cnt", 32'(passCnt), 0);
    checkOutput("mid rst fail_cnt", 32'(failCnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    noValid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (chkValid) noValid = 1'b0;
    end
    checkOutput("no spurious chk_valid", 32'(noValid), 1);
    runTx("post reset", vecs[0]);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 4; i++) begin
      runTx($sformatf("sat%0d", i), vecs[3]);
    end
    checkOutput("sat fail_cnt held", 32'(satFailCnt), 3);
    checkOutput("sat pass_cnt", 32'(satPassCnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
